// File: rtl/proj_input_mux_seq_pkg.sv
// Shared types and helpers for the sequenced project input mux.
// Holds the switch FSM state encoding and select normalisation.
package proj_mux_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int norm_sel(
    input int s,
    input int n
  );
    return (s >= n) ? n : s;
  endfunction

endpackage

// File: rtl/proj_input_mux_seq_if.sv
// Pad-ring side bundle of the project input mux.
// master drives select/inputs, slave is the mux itself.
interface proj_input_mux_seq_if #(
  parameter int N_PROJ     = 4,
  parameter int INPUT_BITS = 8,
  parameter int SEL_BITS   = 3
);

  logic [SEL_BITS-1:0]          sel;
  logic                         ext_rst_n;
  logic [INPUT_BITS-1:0]        in;
  logic                         busy;
  logic [SEL_BITS-1:0]          active_sel;
  logic [N_PROJ-1:0]            proj_clk;
  logic [N_PROJ-1:0]            proj_rst_n;
  logic [N_PROJ*INPUT_BITS-1:0] proj_in;

  modport master (
    output sel, ext_rst_n, in,
    input  busy, active_sel,
    input  proj_clk, proj_rst_n, proj_in
  );

  modport slave (
    input  sel, ext_rst_n, in,
    output busy, active_sel,
    output proj_clk, proj_rst_n, proj_in
  );

endinterface

// File: rtl/proj_input_mux_seq_clk_gate.sv
// Per-project clock gate: registered enable ORed onto the clock.
// Enable only changes at posedge, while clk is high, so no runts.
module proj_clk_gate (
  input  logic clk,
  input  logic rst,
  input  logic en_d,
  output logic gclk
);

  logic en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) en <= 1'b0;
    else     en <= en_d;
  end

  assign gclk = clk | ~en;

endmodule

// File: rtl/proj_input_mux_seq.sv
// Sequenced project input mux: gate, hold in reset, then run.
// Optional SEL_SYNC_EN adds a 2-flop select synchroniser.
module proj_input_mux_seq
  import proj_mux_pkg::*;
#(
  parameter int N_PROJ     = 4,
  parameter int INPUT_BITS = 8,
  parameter int SEL_BITS   = 3,
  parameter int RST_HOLD   = 4
) (
  input logic                 clk,
  input logic                 rst,
  proj_input_mux_seq_if.slave bus
);

  localparam logic [SEL_BITS-1:0] NONE =
    SEL_BITS'(N_PROJ);
  localparam logic [7:0] HOLD_LD =
    8'(RST_HOLD - 1);

  logic [SEL_BITS-1:0] sel_s;

`ifdef SEL_SYNC_EN
  logic [SEL_BITS-1:0] sel_m;
  logic [SEL_BITS-1:0] sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_m <= NONE;
      sel_q <= NONE;
    end else begin
      sel_m <= bus.sel;
      sel_q <= sel_m;
    end
  end

  assign sel_s =
    SEL_BITS'(norm_sel(32'(sel_q), N_PROJ));
`else
  assign sel_s =
    SEL_BITS'(norm_sel(32'(bus.sel), N_PROJ));
`endif

  state_t              state, state_n;
  logic [SEL_BITS-1:0] cur, cur_n;
  logic [SEL_BITS-1:0] tgt, tgt_n;
  logic [7:0]          cnt, cnt_n;
  logic [SEL_BITS-1:0] en_sel;
  logic                en_on;
  logic [N_PROJ-1:0]   en_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GATE;
      cur   <= NONE;
      tgt   <= NONE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    tgt_n   = tgt;
    cnt_n   = cnt;
    en_sel  = cur;
    en_on   = 1'b0;
    unique case (state)
      RUN: begin
        if (sel_s != cur) begin
          tgt_n   = sel_s;
          state_n = GATE;
        end else begin
          en_on = 1'b1;
        end
      end
      GATE: begin
        cur_n  = tgt;
        cnt_n  = HOLD_LD;
        en_sel = tgt;
        if (tgt == NONE) begin
          state_n = RUN;
        end else begin
          en_on   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (sel_s != cur) begin
          tgt_n   = sel_s;
          state_n = GATE;
        end else begin
          en_on = 1'b1;
          if (cnt == 8'd0) state_n = RUN;
          else             cnt_n   = cnt - 8'd1;
        end
      end
      default: state_n = GATE;
    endcase
    for (int i = 0; i < N_PROJ; i++) begin
      en_n[i] = en_on &&
        (en_sel == SEL_BITS'(i));
    end
  end

  logic [N_PROJ-1:0]            gclk;
  logic [N_PROJ-1:0]            rst_v;
  logic [N_PROJ*INPUT_BITS-1:0] in_v;

  for (genvar g = 0; g < N_PROJ; g++) begin : g_gate
    proj_clk_gate u_gate (
      .clk  (clk),
      .rst  (rst),
      .en_d (en_n[g]),
      .gclk (gclk[g])
    );
  end

  // Decode from state registers only; sel never reaches outputs.
  always_comb begin
    rst_v = '0;
    in_v  = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      if (cur == SEL_BITS'(i)) begin
        if (state == RUN)
          rst_v[i] = bus.ext_rst_n;
        if (state != GATE)
          in_v[i*INPUT_BITS +: INPUT_BITS] = bus.in;
      end
    end
  end

  assign bus.proj_clk   = gclk;
  assign bus.proj_rst_n = rst_v;
  assign bus.proj_in    = in_v;
  assign bus.busy       = (state != RUN);
  assign bus.active_sel =
    (state == RUN) ? cur : NONE;

endmodule

// File: tb/tb_proj_input_mux_seq.sv
// Directed bench for proj_input_mux_seq, default build.
// N_PROJ=4, INPUT_BITS=8, RST_HOLD=3.
module tb_proj_input_mux_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  proj_input_mux_seq_if #(
    .N_PROJ(4), .INPUT_BITS(8), .SEL_BITS(3)
  ) bus ();

  proj_input_mux_seq #(
    .N_PROJ(4), .INPUT_BITS(8),
    .SEL_BITS(3), .RST_HOLD(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sel = 3'd1;
    bus.in = 8'hA5;
    bus.ext_rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (bus.proj_clk !== 4'hF) begin
      bad++;
      $display("FAIL rst_clk got=%h exp=F",
        bus.proj_clk);
    end
    total++;
    if (bus.proj_rst_n !== 4'h0) begin
      bad++;
      $display("FAIL rst_rstn got=%h exp=0",
        bus.proj_rst_n);
    end
    total++;
    if (bus.proj_in !== 32'h0) begin
      bad++;
      $display("FAIL rst_in got=%h exp=0",
        bus.proj_in);
    end
    total++;
    if (bus.busy !== 1'b1 ||
        bus.active_sel !== 3'd4) begin
      bad++;
      $display("FAIL rst_stat got=%b/%0d exp=1/4",
        bus.busy, bus.active_sel);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'hF) begin
      bad++;
      $display("FAIL rst_clk_lo got=%h exp=F",
        bus.proj_clk);
    end
  endtask

  task automatic test_startup();
    int lows;
    bit done;
    lows = 0;
    done = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      half();
      if (bus.proj_clk[1] === 1'b0 &&
          bus.proj_rst_n[1] === 1'b0)
        lows++;
      tick();
      if (bus.active_sel === 3'd1) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL start_to got=%0d exp=1",
        bus.active_sel);
    end
    total++;
    if (lows !== 3) begin
      bad++;
      $display("FAIL start_hold got=%0d exp=3",
        lows);
    end
    total++;
    if (bus.proj_rst_n !== 4'b0010 ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL start_run got=%b/%b exp=0010/0",
        bus.proj_rst_n, bus.busy);
    end
    total++;
    if (bus.proj_in !== 32'h0000A500) begin
      bad++;
      $display("FAIL start_in got=%h exp=0000a500",
        bus.proj_in);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'b1101) begin
      bad++;
      $display("FAIL start_clk got=%b exp=1101",
        bus.proj_clk);
    end
    tick();
  endtask

  task automatic test_switch();
    bus.sel = 3'd2;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL sw_busy got=%b exp=1",
        bus.busy);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'hF ||
        bus.proj_rst_n !== 4'h0 ||
        bus.proj_in !== 32'h0) begin
      bad++;
      $display("FAIL sw_gate got=%b/%b/%h exp=1111/0000/0",
        bus.proj_clk, bus.proj_rst_n, bus.proj_in);
    end
    tick();
    total++;
    if (bus.active_sel !== 3'd4 ||
        bus.proj_in !== 32'h00A50000) begin
      bad++;
      $display("FAIL sw_hold got=%0d/%h exp=4/00a50000",
        bus.active_sel, bus.proj_in);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'b1011 ||
        bus.proj_rst_n !== 4'h0) begin
      bad++;
      $display("FAIL sw_hclk got=%b/%b exp=1011/0000",
        bus.proj_clk, bus.proj_rst_n);
    end
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL sw_len got=%b exp=1",
        bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 ||
        bus.active_sel !== 3'd2 ||
        bus.proj_rst_n !== 4'b0100) begin
      bad++;
      $display("FAIL sw_run got=%b/%0d/%b exp=0/2/0100",
        bus.busy, bus.active_sel, bus.proj_rst_n);
    end
  endtask

  task automatic test_abort();
    bus.sel = 3'd1;
    tick();
    tick();
    tick();
    total++;
    if (bus.proj_in !== 32'h0000A500 ||
        bus.proj_rst_n !== 4'h0) begin
      bad++;
      $display("FAIL ab_hold got=%h/%b exp=0000a500/0000",
        bus.proj_in, bus.proj_rst_n);
    end
    bus.sel = 3'd3;
    tick();
    total++;
    if (bus.busy !== 1'b1 ||
        bus.active_sel !== 3'd4) begin
      bad++;
      $display("FAIL ab_busy got=%b/%0d exp=1/4",
        bus.busy, bus.active_sel);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'hF ||
        bus.proj_in !== 32'h0) begin
      bad++;
      $display("FAIL ab_gate got=%b/%h exp=1111/0",
        bus.proj_clk, bus.proj_in);
    end
    tick();
    half();
    total++;
    if (bus.proj_clk !== 4'b0111) begin
      bad++;
      $display("FAIL ab_hclk got=%b exp=0111",
        bus.proj_clk);
    end
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ab_len got=%b exp=1",
        bus.busy);
    end
    bus.in = 8'h3C;
    tick();
    total++;
    if (bus.active_sel !== 3'd3 ||
        bus.proj_rst_n !== 4'b1000 ||
        bus.proj_in !== 32'h3C000000) begin
      bad++;
      $display("FAIL ab_run got=%0d/%b/%h exp=3/1000/3c000000",
        bus.active_sel, bus.proj_rst_n, bus.proj_in);
    end
  endtask

  task automatic test_out_of_range();
    bus.sel = 3'd7;
    tick();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL oor_busy got=%b exp=1",
        bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 ||
        bus.active_sel !== 3'd4) begin
      bad++;
      $display("FAIL oor_run got=%b/%0d exp=0/4",
        bus.busy, bus.active_sel);
    end
    total++;
    if (bus.proj_in !== 32'h0 ||
        bus.proj_rst_n !== 4'h0) begin
      bad++;
      $display("FAIL oor_out got=%h/%b exp=0/0000",
        bus.proj_in, bus.proj_rst_n);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'hF) begin
      bad++;
      $display("FAIL oor_clk got=%b exp=1111",
        bus.proj_clk);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL oor_stay got=%b exp=0",
        bus.busy);
    end
  endtask

  task automatic test_ext_rst();
    bus.sel = 3'd0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (bus.active_sel !== 3'd0 ||
        bus.proj_rst_n !== 4'b0001) begin
      bad++;
      $display("FAIL ext_run got=%0d/%b exp=0/0001",
        bus.active_sel, bus.proj_rst_n);
    end
    bus.ext_rst_n = 1'b0;
    #1;
    total++;
    if (bus.proj_rst_n !== 4'h0 ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ext_lo got=%b/%b exp=0000/0",
        bus.proj_rst_n, bus.busy);
    end
    tick();
    tick();
    total++;
    if (bus.proj_rst_n !== 4'h0 ||
        bus.active_sel !== 3'd0) begin
      bad++;
      $display("FAIL ext_lo2 got=%b/%0d exp=0000/0",
        bus.proj_rst_n, bus.active_sel);
    end
    bus.ext_rst_n = 1'b1;
    #1;
    total++;
    if (bus.proj_rst_n !== 4'b0001 ||
        bus.proj_in !== 32'h0000003C) begin
      bad++;
      $display("FAIL ext_hi got=%b/%h exp=0001/0000003c",
        bus.proj_rst_n, bus.proj_in);
    end
    half();
    total++;
    if (bus.proj_clk !== 4'b1110) begin
      bad++;
      $display("FAIL ext_clk got=%b exp=1110",
        bus.proj_clk);
    end
    tick();
  endtask

  task automatic test_async_rst();
    bit done;
    done = 0;
    bus.sel = 3'd2;
    tick();
    tick();
    half();
    total++;
    if (bus.proj_clk !== 4'b1011) begin
      bad++;
      $display("FAIL ar_pre got=%b exp=1011",
        bus.proj_clk);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.proj_clk !== 4'hF ||
        bus.proj_rst_n !== 4'h0 ||
        bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ar_now got=%b/%b/%b exp=1111/0000/1",
        bus.proj_clk, bus.proj_rst_n, bus.busy);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (bus.active_sel === 3'd2) done = 1;
    end
    total++;
    if (!done ||
        bus.proj_rst_n !== 4'b0100 ||
        bus.proj_in !== 32'h003C0000) begin
      bad++;
      $display("FAIL ar_back got=%0d/%b/%h exp=2/0100/003c0000",
        bus.active_sel, bus.proj_rst_n, bus.proj_in);
    end
  endtask

  task automatic test_back_to_back();
    bus.sel = 3'd1;
    #3;
    bus.sel = 3'd2;
    tick();
    total++;
    if (bus.busy !== 1'b0 ||
        bus.active_sel !== 3'd2) begin
      bad++;
      $display("FAIL b2b got=%b/%0d exp=0/2",
        bus.busy, bus.active_sel);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_startup();
    test_switch();
    test_abort();
    test_out_of_range();
    test_ext_rst();
    test_async_rst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule
